// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester ports, the shared response signals and the
// memory-side strobes of the two-port memory arbiter.
//   Requester side : req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 (to arbiter)
//                    ack0/ack1, rdata, gnt, busy (from arbiter)
//   Memory side    : mem_read, mem_write, mem_addr, mem_wdata (from arbiter)
//                    mem_rdata (to arbiter)
// Modports: slave = arbiter view, master = requesters plus memory model view.
interface mem_port_arbiter_if #(
    parameter int size    = 8,
    parameter int memsize = 7
);
    logic               req0;
    logic               req1;
    logic               we0;
    logic               we1;
    logic [memsize-1:0] addr0;
    logic [memsize-1:0] addr1;
    logic [size-1:0]    wdata0;
    logic [size-1:0]    wdata1;
    logic               ack0;
    logic               ack1;
    logic [size-1:0]    rdata;
    logic [1:0]         gnt;
    logic               busy;
    logic               mem_read;
    logic               mem_write;
    logic [memsize-1:0] mem_addr;
    logic [size-1:0]    mem_wdata;
    logic [size-1:0]    mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata, gnt, busy, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata, gnt, busy, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter granting one of two requesters access to a single
// memory port. One transaction at a time: IDLE -> ACCESS -> (WAIT) -> RESP.
// Writes take IDLE/ACCESS/RESP, reads add a WAIT cycle to capture mem_rdata.
// All outputs are registered; they are decoded from the next state so that
// each output is aligned with the state it belongs to.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   arb  - mem_port_arbiter_if slave modport (requesters and memory)
module mem_port_arbiter #(
    parameter int size    = 8,
    parameter int memsize = 7
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave arb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               owner_r;      // 0 = requester 0, 1 = requester 1
    logic               owner_s;
    logic               last_r;       // requester served most recently
    logic               last_s;
    logic               we_r;
    logic               we_s;
    logic [memsize-1:0] addr_r;
    logic [memsize-1:0] addr_s;
    logic [size-1:0]    wdata_r;
    logic [size-1:0]    wdata_s;
    logic [size-1:0]    rdata_r;
    logic [size-1:0]    rdata_s;
    logic [1:0]         gnt_r;
    logic [1:0]         gnt_s;
    logic               ack0_r;
    logic               ack0_s;
    logic               ack1_r;
    logic               ack1_s;
    logic               mem_read_r;
    logic               mem_read_s;
    logic               mem_write_r;
    logic               mem_write_s;
    logic               busy_r;
    logic               busy_s;
    logic               win_s;

    // Winner selection: a lone request wins, a tie goes to the requester not served last
    always_comb begin
        win_s = 1'b0;
        if (arb.req0 && arb.req1) begin
            win_s = ~last_r;
        end else begin
            win_s = arb.req1;
        end
    end

    // Next-state decode plus next values of every registered output
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        last_s      = last_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        rdata_s     = rdata_r;
        gnt_s       = gnt_r;
        ack0_s      = 1'b0;
        ack1_s      = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        busy_s      = busy_r;
        case (state_r)
            IDLE: begin
                if (arb.req0 || arb.req1) begin
                    owner_s = win_s;
                    if (win_s) begin
                        we_s    = arb.we1;
                        addr_s  = arb.addr1;
                        wdata_s = arb.wdata1;
                        gnt_s   = 2'b10;
                    end else begin
                        we_s    = arb.we0;
                        addr_s  = arb.addr0;
                        wdata_s = arb.wdata0;
                        gnt_s   = 2'b01;
                    end
                    // Strobes belong to ACCESS, which is the state being entered
                    mem_write_s = we_s;
                    mem_read_s  = ~we_s;
                    busy_s      = 1'b1;
                    state_s     = ACCESS;
                end else begin
                    gnt_s  = 2'b00;
                    busy_s = 1'b0;
                end
            end
            ACCESS: begin
                busy_s = 1'b1;
                if (we_r) begin
                    // Entering RESP: raise the owner's ack for that one cycle
                    ack0_s  = ~owner_r;
                    ack1_s  = owner_r;
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                // Memory answers one cycle after mem_read, i.e. during WAIT
                rdata_s = arb.mem_rdata;
                ack0_s  = ~owner_r;
                ack1_s  = owner_r;
                busy_s  = 1'b1;
                state_s = RESP;
            end
            RESP: begin
                last_s  = owner_r;
                gnt_s   = 2'b00;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                gnt_s   = 2'b00;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, captured request and output registers; reset aborts any transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            last_r      <= 1'b1;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            gnt_r       <= 2'b00;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            rdata_r     <= rdata_s;
            gnt_r       <= gnt_s;
            ack0_r      <= ack0_s;
            ack1_r      <= ack1_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            busy_r      <= busy_s;
        end
    end

    assign arb.gnt       = gnt_r;
    assign arb.ack0      = ack0_r;
    assign arb.ack1      = ack1_r;
    assign arb.rdata     = rdata_r;
    assign arb.busy      = busy_r;
    assign arb.mem_read  = mem_read_r;
    assign arb.mem_write = mem_write_r;
    assign arb.mem_addr  = addr_r;
    assign arb.mem_wdata = wdata_r;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter size, default 8, data word width in bits.
REQ-002 Parameter memsize, default 7, memory address width in bits.
REQ-003 Clock and reset: one clock, reset asynchronous and active-low.
REQ-004 clk  input  1  clock, rising-edge active.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 req0, req1  input  1 each  access request; held high until the matching ack.
REQ-007 we0, we1  input  1 each  1 = write, 0 = read; sampled at grant.
REQ-008 addr0, addr1  input  memsize each  access address; sampled at grant.
REQ-009 wdata0, wdata1  input  size each  write data; sampled at grant.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  size  read data, valid in the ack cycle.
REQ-012 gnt  output  2  one-hot owner: 01 = requester 0, 10 = requester 1, 00 = none.
REQ-013 mem_read, mem_write  output  1 each  memory strobes.
REQ-014 mem_addr  output  memsize  memory address.
REQ-015 mem_wdata  output  size  memory write data.
REQ-016 mem_rdata  input  size  memory read data, valid one cycle after mem_read.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, WAIT, RESP.
REQ-019 IDLE, no request: stays in IDLE with gnt = 00.
REQ-020 IDLE, any req high: picks a winner, registers its we/addr/wdata, sets gnt and moves to ACCESS on the next edge.
REQ-021 Arbitration: if only one req is high, that requester wins.
REQ-022 Arbitration: if both req are high, the requester not served last wins (round-robin); after reset the last-served pointer points to requester 1, so requester 0 wins the first tie.
REQ-023 ACCESS: exactly one cycle; mem_write = we or mem_read = !we, with mem_addr/mem_wdata from the registered values.
REQ-024 ACCESS, write: next state RESP.
REQ-025 ACCESS, read: next state WAIT.
REQ-026 WAIT: no strobes; captures mem_rdata into the rdata register; next state RESP.
REQ-027 RESP: ack of the owner high for exactly one cycle; rdata holds the captured value (unchanged for writes); last-served pointer updates to the owner; next state IDLE; gnt clears in IDLE.
REQ-028 Latency from req high in IDLE to ack: write 3 cycles, read 4 cycles.
REQ-029 Back-to-back: after RESP, IDLE re-arbitrates, so two held requests alternate with one IDLE cycle between transactions.
REQ-030 Strobes are never both high; mem_read/mem_write are high only in ACCESS.
REQ-031 gnt is constant from ACCESS through RESP; exactly one ack per grant.
REQ-032 Owner dropping req after grant (protocol violation): the transaction still completes and the ack is still issued.
REQ-033 Non-owner req or input changes during a transaction: ignored until IDLE.
REQ-034 Address and data are not range-checked; mem_addr passes the full memsize bits unchanged.

Reset
REQ-035 On rst low, immediately and asynchronously: state IDLE, gnt 00, ack0/ack1 0, mem_read/mem_write 0, busy 0, rdata 0, mem_addr 0, mem_wdata 0, last-served pointer = requester 1.
REQ-036 Reset mid-transaction aborts it with no ack; the first edge after rst rises evaluates IDLE.

Verification
REQ-037 Reset, then req0 = 1, we0 = 1, addr0 = 5, wdata0 = 8'hA5 -> mem_write high for one cycle with mem_addr 5 and mem_wdata A5; ack0 3 cycles after req0 was raised.
REQ-038 req1 read addr 5, memory model returns A5 one cycle after mem_read -> rdata = A5 with ack1 4 cycles after req; gnt = 10 throughout.
REQ-039 req0 and req1 raised in the same cycle and held -> grant order 0, 1, 0, 1; one IDLE cycle between each ack.
REQ-040 rst pulsed low during WAIT of a read -> all outputs at reset values immediately; no ack; the next tie goes to requester 0.
REQ-041 req0 dropped in ACCESS -> ack0 still pulses in RESP; no further grant to requester 0.
REQ-042 Over 1000 random cycles -> strobes never both high, at most one ack per cycle, and acks per requester equal grants per requester.
